mac_buffer_ctrl: RTL and testbench

Sequencer for the MAC operand buffer, a register file with one write port and two combinational read ports.
- Accepts a valid/ready operand stream of alternating A and B words and writes it into the buffer.
- Issues A/B pairs to the MAC through the two read ports, with a clear/enable handshake to the accumulator.
- Signals completion after a programmed number of pairs.
- Sits between the operand source and the buffer/MAC datapath.

---
 rtl/mac_buffer_ctrl.sv | 131 +++++++++++++
 tb/tb_mac_buffer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mac_buffer_ctrl.sv
// Operand-buffer sequencer: streams A/B words into the buffer, issues pairs to the MAC, pulses done.
// Pair eligible the cycle after its B word lands; in_ready drops when the buffer is full or the job's words are in.
module mac_buffer_ctrl #(
    parameter int BufferSize  = 4,
    parameter int BufferWidth = 2,
    parameter int CountWidth  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CountWidth-1:0]  num_pairs,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   buf_en,
    output logic [BufferWidth-1:0] buf_waddr,
    output logic [BufferWidth-1:0] buf_raddr1,
    output logic [BufferWidth-1:0] buf_raddr2,
    input  logic                   mac_ready,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   busy,
    output logic                   done
);

    localparam int CntW = BufferWidth + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [BufferWidth-1:0] wr_ptr_q,    wr_ptr_d;
    logic [BufferWidth-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CntW-1:0]        count_q,     count_d;
    logic [CountWidth:0]    words_in_q,  words_in_d;
    logic [CountWidth-1:0]  pairs_out_q, pairs_out_d;
    logic [CountWidth-1:0]  n_lat_q,     n_lat_d;

    logic running;
    logic accept;

    assign running = (state_q == RUN);

    // in_ready depends only on registered state, so a same-cycle issue never frees a slot early.
    assign in_ready = running
                   && (count_q < CntW'(BufferSize))
                   && (words_in_q < {n_lat_q, 1'b0});
    assign accept   = in_valid && in_ready;

    assign mac_en   = running
                   && (count_q >= CntW'(2))
                   && (pairs_out_q < n_lat_q)
                   && mac_ready;

    assign buf_en     = accept;
    assign buf_waddr  = wr_ptr_q;
    assign buf_raddr1 = rd_ptr_q;
    assign buf_raddr2 = rd_ptr_q + BufferWidth'(1);

    assign mac_clr = (state_q == IDLE) && start && !rst;
    assign busy    = running;
    assign done    = (state_q == DONE);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        words_in_d  = words_in_q;
        pairs_out_d = pairs_out_q;
        n_lat_d     = n_lat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_lat_d     = num_pairs;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                    words_in_d  = '0;
                    pairs_out_d = '0;
                    state_d     = (num_pairs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    wr_ptr_d   = wr_ptr_q + BufferWidth'(1);
                    words_in_d = words_in_q + (CountWidth+1)'(1);
                end
                if (mac_en) begin
                    rd_ptr_d    = rd_ptr_q + BufferWidth'(2);
                    pairs_out_d = pairs_out_q + CountWidth'(1);
                end
                count_d = count_q + CntW'(accept) - (mac_en ? CntW'(2) : CntW'(0));
                // n_lat is nonzero in RUN, so the subtraction cannot wrap.
                if (mac_en && (pairs_out_q == n_lat_q - CountWidth'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            words_in_q  <= '0;
            pairs_out_q <= '0;
            n_lat_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            words_in_q  <= words_in_d;
            pairs_out_q <= pairs_out_d;
            n_lat_q     <= n_lat_d;
        end
    end

endmodule

// File: tb/tb_mac_buffer_ctrl.sv
// Directed bench for mac_buffer_ctrl: inputs change 1ns after the rising edge, outputs are checked 1ns later.
// Expected values are hand-traced per cycle for a 4-deep buffer.
module tb_mac_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_pairs;
    logic       in_valid;
    logic       in_ready;
    logic       buf_en;
    logic [1:0] buf_waddr;
    logic [1:0] buf_raddr1;
    logic [1:0] buf_raddr2;
    logic       mac_ready;
    logic       mac_clr;
    logic       mac_en;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_buffer_ctrl #(
        .BufferSize (4),
        .BufferWidth(2),
        .CountWidth (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pairs (num_pairs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .buf_en    (buf_en),
        .buf_waddr (buf_waddr),
        .buf_raddr1(buf_raddr1),
        .buf_raddr2(buf_raddr2),
        .mac_ready (mac_ready),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic st, input logic [7:0] np, input logic v, input logic mr);
        start     = st;
        num_pairs = np;
        in_valid  = v;
        mac_ready = mr;
        #1;
    endtask

    task automatic io(input string tag, input logic ir, input logic be, input logic [1:0] wa,
                      input logic me, input logic [1:0] r1, input logic [1:0] r2);
        chk({tag, ".in_ready"}, in_ready, ir);
        chk({tag, ".buf_en"}, buf_en, be);
        chk({tag, ".waddr"}, buf_waddr, wa);
        chk({tag, ".mac_en"}, mac_en, me);
        chk({tag, ".raddr1"}, buf_raddr1, r1);
        chk({tag, ".raddr2"}, buf_raddr2, r2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; num_pairs = 8'd0; in_valid = 1'b1; mac_ready = 1'b1;
        #2;
        io("rst0", 0, 0, 0, 0, 0, 1);
        chk("rst0.mac_clr", mac_clr, 0);
        chk("rst0.busy", busy, 0);
        chk("rst0.done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drv(0, 0, 0, 0);
        chk("idle0.busy", busy, 0);

        // reset in the middle of a job, count=3, rd_ptr=2
        nxt(); drv(1, 4, 0, 0);
        chk("t1s.mac_clr", mac_clr, 1);
        nxt(); drv(0, 0, 1, 1); io("t1r0", 1, 1, 0, 0, 0, 1);
        nxt();                  io("t1r1", 1, 1, 1, 0, 0, 1);
        nxt();                  io("t1r2", 1, 1, 2, 1, 0, 1);
        nxt(); drv(0, 0, 1, 0); io("t1r3", 1, 1, 3, 0, 2, 3);
        nxt();                  io("t1r4", 1, 1, 0, 0, 2, 3);
        nxt(); drv(0, 0, 1, 1); io("t1r5", 1, 1, 1, 1, 2, 3);
        rst = 1'b1; #1;
        io("t1rst", 0, 0, 0, 0, 0, 1);
        chk("t1rst.busy", busy, 0);
        chk("t1rst.mac_clr", mac_clr, 0);
        nxt(); nxt();
        rst = 1'b0;
        drv(0, 0, 1, 1);
        io("t1idle", 0, 0, 0, 0, 0, 1);
        chk("t1idle.busy", busy, 0);
        chk("t1idle.done", done, 0);

        // streaming, 3 pairs
        nxt(); drv(1, 3, 1, 1);
        chk("t2s.mac_clr", mac_clr, 1);
        io("t2s", 0, 0, 0, 0, 0, 1);
        nxt(); drv(0, 0, 1, 1); io("t2r0", 1, 1, 0, 0, 0, 1);
        chk("t2r0.busy", busy, 1);
        chk("t2r0.mac_clr", mac_clr, 0);
        nxt(); io("t2r1", 1, 1, 1, 0, 0, 1);
        nxt(); io("t2r2", 1, 1, 2, 1, 0, 1);
        nxt(); io("t2r3", 1, 1, 3, 0, 2, 3);
        nxt(); io("t2r4", 1, 1, 0, 1, 2, 3);
        nxt(); io("t2r5", 1, 1, 1, 0, 0, 1);
        nxt(); io("t2r6", 0, 0, 2, 1, 0, 1);
        chk("t2r6.done", done, 0);
        nxt(); io("t2d", 0, 0, 2, 0, 2, 3);
        chk("t2d.done", done, 1);
        chk("t2d.busy", busy, 0);
        nxt(); drv(0, 0, 0, 0);
        chk("t2i.done", done, 0);
        chk("t2i.busy", busy, 0);

        // full buffer and backpressure, start pulse during RUN ignored
        nxt(); drv(1, 4, 1, 0);
        chk("t3s.mac_clr", mac_clr, 1);
        nxt(); drv(0, 0, 1, 0); io("t3r0", 1, 1, 0, 0, 0, 1);
        nxt(); io("t3r1", 1, 1, 1, 0, 0, 1);
        nxt(); io("t3r2", 1, 1, 2, 0, 0, 1);
        nxt(); io("t3r3", 1, 1, 3, 0, 0, 1);
        nxt(); drv(1, 1, 1, 0); io("t3r4", 0, 0, 0, 0, 0, 1);
        chk("t3r4.mac_clr", mac_clr, 0);
        nxt(); drv(0, 0, 1, 1); io("t3r5", 0, 0, 0, 1, 0, 1);
        nxt(); io("t3r6", 1, 1, 0, 1, 2, 3);
        nxt(); io("t3r7", 1, 1, 1, 0, 0, 1);
        chk("t3r7.busy", busy, 1);
        nxt(); io("t3r8", 1, 1, 2, 1, 0, 1);
        nxt(); io("t3r9", 1, 1, 3, 0, 2, 3);
        nxt(); io("t3r10", 0, 0, 0, 1, 2, 3);
        nxt(); chk("t3d.done", done, 1);
        chk("t3d.in_ready", in_ready, 0);
        nxt(); drv(0, 0, 0, 0);
        chk("t3i.done", done, 0);

        // zero-length job
        nxt(); drv(1, 0, 1, 1);
        chk("t4s.mac_clr", mac_clr, 1);
        chk("t4s.in_ready", in_ready, 0);
        nxt(); drv(0, 0, 1, 1);
        chk("t4d.done", done, 1);
        chk("t4d.busy", busy, 0);
        io("t4d", 0, 0, 0, 0, 0, 1);
        nxt();
        chk("t4i.done", done, 0);
        io("t4i", 0, 0, 0, 0, 0, 1);

        // gapped input, 2 pairs
        nxt(); drv(1, 2, 0, 1);
        chk("t6s.mac_clr", mac_clr, 1);
        nxt(); drv(0, 0, 1, 1); io("t6r0", 1, 1, 0, 0, 0, 1);
        nxt(); drv(0, 0, 0, 1); io("t6r1", 1, 0, 1, 0, 0, 1);
        nxt();                  io("t6r2", 1, 0, 1, 0, 0, 1);
        nxt(); drv(0, 0, 1, 1); io("t6r3", 1, 1, 1, 0, 0, 1);
        nxt();                  io("t6r4", 1, 1, 2, 1, 0, 1);
        nxt(); drv(0, 0, 0, 1); io("t6r5", 1, 0, 3, 0, 2, 3);
        nxt(); drv(0, 0, 1, 1); io("t6r6", 1, 1, 3, 0, 2, 3);
        nxt(); drv(0, 0, 0, 1); io("t6r7", 0, 0, 0, 1, 2, 3);
        nxt(); chk("t6d.done", done, 1);
        chk("t6d.mac_en", mac_en, 0);
        nxt(); chk("t6i.done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
